// File: rtl/params_pkg.sv
// Shared architectural constants for the hazard scoreboard.
package params_pkg;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;
endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register.
// Simultaneous inc and dec cancel out; clr has priority over both.
module sb_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && !dec_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (dec_i && !inc_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;
endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for long-latency writes, with an optional stall
// watchdog enabled by defining HAZARD_TIMEOUT_EN.
module hazard_scoreboard
  import params_pkg::*;
#(
  parameter int NUM_READ_PORTS  = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               id_valid_i,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] id_rs_addr_i,
  input  logic                               id_issue_i,
  input  logic [REG_ADDR_W-1:0]              id_rd_addr_i,
  input  logic                               cmpl_valid_i,
  input  logic [REG_ADDR_W-1:0]              cmpl_rd_addr_i,
  input  logic                               flush_i,
  output logic                               id_stall_o,
  output logic                               busy_o,
  output logic [CNT_W-1:0]                   pending_cnt_o,
  output logic                               timeout_o
);
  logic [CNT_W-1:0]          r_total;
  logic [CNT_W-1:0]          w_cnt [NUM_ARCH_REGS];
  logic                      w_full;
  logic                      w_issue_ok;
  logic                      w_cmpl_ok;
  logic [NUM_READ_PORTS-1:0] w_port_hit;

  assign w_full     = (r_total == CNT_W'(MAX_OUTSTANDING));
  assign w_issue_ok = id_issue_i && (id_rd_addr_i != '0) && !w_full;
  assign w_cmpl_ok  = cmpl_valid_i && (cmpl_rd_addr_i != '0) && (w_cnt[cmpl_rd_addr_i] != '0);

  assign w_cnt[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_ARCH_REGS; gi++) begin : g_reg
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_issue_ok && (id_rd_addr_i == REG_ADDR_W'(gi))),
        .dec_i (w_cmpl_ok && (cmpl_rd_addr_i == REG_ADDR_W'(gi))),
        .clr_i (flush_i),
        .cnt_o (w_cnt[gi])
      );
    end

    // A reader whose last pending write retires this cycle can take the
    // forwarded result, unless a new write to that register issues alongside.
    for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_port
      logic [REG_ADDR_W-1:0] w_rs;
      logic                  w_drop;
      assign w_rs   = id_rs_addr_i[gi*REG_ADDR_W +: REG_ADDR_W];
      assign w_drop = w_cmpl_ok && (cmpl_rd_addr_i == w_rs) &&
                      (w_cnt[w_rs] == CNT_W'(1)) &&
                      !(w_issue_ok && (id_rd_addr_i == w_rs));
      assign w_port_hit[gi] = (w_rs != '0) && (w_cnt[w_rs] != '0) && !w_drop;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_total <= '0;
    end else if (flush_i) begin
      r_total <= '0;
    end else if (w_issue_ok && !w_cmpl_ok) begin
      r_total <= r_total + CNT_W'(1);
    end else if (w_cmpl_ok && !w_issue_ok) begin
      r_total <= r_total - CNT_W'(1);
    end
  end

  assign id_stall_o    = id_valid_i && ((|w_port_hit) || w_full);
  assign busy_o        = (r_total != '0);
  assign pending_cnt_o = r_total;

`ifdef HAZARD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;
  logic            w_wd_hit;

  assign w_wd_hit = id_stall_o && !flush_i && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd <= '0;
    end else if (!id_stall_o || flush_i || w_wd_hit) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  assign timeout_o = w_wd_hit;
`else
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; the watchdog
// sequence is exercised only when HAZARD_TIMEOUT_EN is defined.
module tb_hazard_scoreboard;
  localparam int NRP   = 2;
  localparam int MAXO  = 4;
  localparam int CNT_W = $clog2(MAXO + 1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             id_valid_i;
  logic [NRP*5-1:0] id_rs_addr_i;
  logic             id_issue_i;
  logic [4:0]       id_rd_addr_i;
  logic             cmpl_valid_i;
  logic [4:0]       cmpl_rd_addr_i;
  logic             flush_i;
  logic             id_stall_o;
  logic             busy_o;
  logic [CNT_W-1:0] pending_cnt_o;
  logic             timeout_o;

  int n_total = 0;
  int n_bad   = 0;

  hazard_scoreboard #(
    .NUM_READ_PORTS (NRP),
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs_addr_i  (id_rs_addr_i),
    .id_issue_i    (id_issue_i),
    .id_rd_addr_i  (id_rd_addr_i),
    .cmpl_valid_i  (cmpl_valid_i),
    .cmpl_rd_addr_i(cmpl_rd_addr_i),
    .flush_i       (flush_i),
    .id_stall_o    (id_stall_o),
    .busy_o        (busy_o),
    .pending_cnt_o (pending_cnt_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    id_valid_i = 0; id_rs_addr_i = '0; id_issue_i = 0; id_rd_addr_i = '0;
    cmpl_valid_i = 0; cmpl_rd_addr_i = '0; flush_i = 0;
  endtask

  task automatic issue(input int rd);
    id_issue_i = 1; id_rd_addr_i = 5'(rd);
    step();
    id_issue_i = 0; id_rd_addr_i = '0;
  endtask

  task automatic cmpl(input int rd);
    cmpl_valid_i = 1; cmpl_rd_addr_i = 5'(rd);
    step();
    cmpl_valid_i = 0; cmpl_rd_addr_i = '0;
  endtask

  task automatic set_rs(input int rs1, input int rs0);
    id_valid_i = 1; id_rs_addr_i = {5'(rs1), 5'(rs0)};
  endtask

  initial begin
    idle_in();
    rst_i = 1;
    #3;
    chk("reset_stall",   int'(id_stall_o), 0);
    chk("reset_busy",    int'(busy_o), 0);
    chk("reset_cnt",     int'(pending_cnt_o), 0);
    chk("reset_timeout", int'(timeout_o), 0);
    step(); step();
    rst_i = 0;
    step();

    // Basic RAW stall with same-cycle completion release
    issue(5);
    set_rs(0, 5);
    #1;
    chk("raw5_stall", int'(id_stall_o), 1);
    chk("raw5_cnt",   int'(pending_cnt_o), 1);
    chk("raw5_busy",  int'(busy_o), 1);
    cmpl_valid_i = 1; cmpl_rd_addr_i = 5'd5;
    #1;
    chk("raw5_cmpl_release", int'(id_stall_o), 0);
    step();
    cmpl_valid_i = 0; cmpl_rd_addr_i = '0;
    chk("raw5_cnt_after", int'(pending_cnt_o), 0);
    chk("raw5_stall_after", int'(id_stall_o), 0);
    idle_in();

    // Fill to MAX_OUTSTANDING, then overflow attempt
    issue(1); issue(2); issue(3); issue(4);
    chk("full_cnt", int'(pending_cnt_o), 4);
    set_rs(11, 10);
    #1;
    chk("full_stall_unrelated", int'(id_stall_o), 1);
    issue(6);
    chk("full_overflow_ignored", int'(pending_cnt_o), 4);
    set_rs(0, 6);
    cmpl(1);
    chk("cnt_after_cmpl1", int'(pending_cnt_o), 3);
    chk("rd6_never_pending", int'(id_stall_o), 0);
    set_rs(3, 0);
    #1;
    chk("port1_rs3_stall", int'(id_stall_o), 1);
    id_valid_i = 0;
    #1;
    chk("no_valid_no_stall", int'(id_stall_o), 0);
    cmpl(2); cmpl(3); cmpl(4);
    chk("drain_cnt", int'(pending_cnt_o), 0);
    chk("drain_busy", int'(busy_o), 0);
    idle_in();

    // Same-cycle issue and completion to the same register
    issue(7);
    id_issue_i = 1; id_rd_addr_i = 5'd7;
    cmpl_valid_i = 1; cmpl_rd_addr_i = 5'd7;
    step();
    idle_in();
    chk("same_cycle_rd7", int'(pending_cnt_o), 1);
    set_rs(0, 7);
    #1;
    chk("rd7_still_stall", int'(id_stall_o), 1);
    cmpl(7);
    chk("rd7_done", int'(pending_cnt_o), 0);
    idle_in();

    // Flush beats a same-cycle issue
    issue(1); issue(2); issue(3);
    chk("pre_flush_cnt", int'(pending_cnt_o), 3);
    flush_i = 1; id_issue_i = 1; id_rd_addr_i = 5'd9;
    step();
    idle_in();
    chk("flush_cnt", int'(pending_cnt_o), 0);
    chk("flush_busy", int'(busy_o), 0);
    set_rs(0, 9);
    #1;
    chk("flush_rs9_stall", int'(id_stall_o), 0);
    set_rs(0, 2);
    #1;
    chk("flush_rs2_stall", int'(id_stall_o), 0);
    idle_in();

    // x0 handling and completion to an idle register
    set_rs(0, 0);
    id_issue_i = 1; id_rd_addr_i = 5'd0;
    #1;
    chk("x0_stall", int'(id_stall_o), 0);
    step();
    idle_in();
    chk("x0_cnt", int'(pending_cnt_o), 0);
    cmpl(12);
    chk("idle_cmpl_cnt0", int'(pending_cnt_o), 0);
    issue(3);
    cmpl(12);
    chk("idle_cmpl_cnt1", int'(pending_cnt_o), 1);
    cmpl(3);
    chk("idle_cmpl_cleanup", int'(pending_cnt_o), 0);

    // Asynchronous reset mid-operation
    issue(2);
    set_rs(0, 2);
    #1;
    chk("prereset_stall", int'(id_stall_o), 1);
    rst_i = 1;
    #1;
    chk("async_rst_stall", int'(id_stall_o), 0);
    chk("async_rst_cnt", int'(pending_cnt_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    step();
    rst_i = 0;
    step();
    chk("post_reset_stall", int'(id_stall_o), 0);
    chk("post_reset_cnt", int'(pending_cnt_o), 0);
    idle_in();

    // Held stall: watchdog pulses in stall cycle 8 when enabled
    issue(5);
    set_rs(0, 5);
    for (int c = 1; c <= 10; c++) begin
      #2;
`ifdef HAZARD_TIMEOUT_EN
      chk($sformatf("wd_cycle%0d", c), int'(timeout_o), (c == 8) ? 1 : 0);
`else
      chk($sformatf("wd_off_cycle%0d", c), int'(timeout_o), 0);
`endif
      step();
    end
    rst_i = 1;
    #1;
    chk("wd_rst_stall", int'(id_stall_o), 0);
    chk("wd_rst_timeout", int'(timeout_o), 0);
    chk("wd_rst_cnt", int'(pending_cnt_o), 0);
    chk("wd_rst_busy", int'(busy_o), 0);
    step();
    rst_i = 0;
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timer: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_READ_PORTS, default 2: number of decode-stage source operands checked each cycle.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: maximum in-flight long-latency writes (loads, mul/div).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: stall watchdog limit, used only when HAZARD_TIMEOUT_EN is defined.
REQ-004 SHALL use one clock, clk_i, with an asynchronous active-high reset, rst_i.
REQ-005 SHALL have port clk_i  in  1  clock.
REQ-006 SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-007 SHALL have port id_valid_i  in  1  decode stage holds a valid instruction.
REQ-008 SHALL have port id_rs_addr_i  in  NUM_READ_PORTS*5  source addresses, port k in bits [5k+4:5k].
REQ-009 SHALL have port id_issue_i  in  1  a long-latency op with rd advances from ID to EX this cycle.
REQ-010 SHALL have port id_rd_addr_i  in  5  destination of the issuing op.
REQ-011 SHALL have port cmpl_valid_i  in  1  a long-latency result writes back this cycle.
REQ-012 SHALL have port cmpl_rd_addr_i  in  5  destination of the completing op.
REQ-013 SHALL have port flush_i  in  1  trap or redirect kills all in-flight ops.
REQ-014 SHALL have port id_stall_o  out  1  hold IF/ID and bubble ID/EX.
REQ-015 SHALL have port busy_o  out  1  any write pending.
REQ-016 SHALL have port pending_cnt_o  out  CNT_W  total pending writes, CNT_W = $clog2(MAX_OUTSTANDING+1).
REQ-017 SHALL have port timeout_o  out  1  watchdog pulse.

Function
REQ-018 SHALL keep, for registers x1..x31, a per-register pending counter of width CNT_W, plus a total counter; x0 has no counter and is never pending.
REQ-019 SHALL, on id_issue_i with id_rd_addr_i != 0 and total < MAX_OUTSTANDING, increment that register's counter and the total at the next edge.
REQ-020 SHALL, on cmpl_valid_i with cmpl_rd_addr_i != 0 and a nonzero counter, decrement that register's counter and the total at the next edge.
REQ-021 SHALL ignore a completion to a zero counter, with no underflow.
REQ-022 SHALL ignore an issue while the total equals MAX_OUTSTANDING, with no overflow.
REQ-023 SHALL leave the counters unchanged when an issue and a completion to the same register occur in the same cycle.
REQ-024 SHALL, on flush_i, clear every counter and the total at the next edge; flush overrides a same-cycle issue or completion.
REQ-025 SHALL drive id_stall_o combinationally: id_valid_i && (any nonzero id_rs_addr_i port whose counter is nonzero, excluding a register whose same-cycle completion drops its counter 1->0, || total == MAX_OUTSTANDING).
REQ-026 SHALL drive busy_o = (total != 0) and pending_cnt_o = total, both registered state, with zero combinational latency from state.

Reset
REQ-027 SHALL, while rst_i is high, asynchronously clear all counters, the total and the watchdog, with id_stall_o=0, busy_o=0, pending_cnt_o=0 and timeout_o=0.
REQ-028 SHALL, when rst_i deasserts mid-operation, discard all prior pending state.

Configuration
REQ-029 SHALL, with HAZARD_TIMEOUT_EN defined, count consecutive cycles with id_stall_o=1, clear the count on any cycle with id_stall_o=0 or on flush_i, and pulse timeout_o for one cycle when the count reaches TIMEOUT_CYCLES, then restart from 0.
REQ-030 SHALL, without HAZARD_TIMEOUT_EN, contain no watchdog logic and tie timeout_o to 0.

Structure
REQ-031 SHALL place REG_ADDR_W=5 and NUM_ARCH_REGS=32 in params_pkg.
REQ-032 SHALL implement each per-register counter as one sub-module, sb_counter, instanced 31 times (inc, dec, clr, cnt).

Verification
REQ-033 SHALL verify: issue rd=5; next cycle id_valid_i with rs1=5 -> id_stall_o=1; cmpl rd=5 -> stall drops that same cycle, and pending_cnt_o reads 0 after the edge.
REQ-034 SHALL verify: 4 issues to rd=1,2,3,4 -> pending_cnt_o=4 and id_stall_o=1 with unrelated rs; a 5th issue is ignored and the count stays at 4.
REQ-035 SHALL verify: issue and cmpl to rd=7 in the same cycle, with rd=7 previously pending once -> count stays 1.
REQ-036 SHALL verify: 3 pending, then flush_i together with issue rd=9 -> pending_cnt_o=0, busy_o=0, and rs=9 does not stall.
REQ-037 SHALL verify: rs=0 with issue rd=0 -> no stall and count 0; cmpl to an idle register -> count unchanged.
REQ-038 SHALL verify, with HAZARD_TIMEOUT_EN and TIMEOUT_CYCLES=8: a held stall -> timeout_o pulses high in exactly stall cycle 8; rst_i asserted mid-stall -> all outputs 0 immediately.
